// File: rtl/crc16_tx_append.sv
// crc16_tx_append
// Bit-serial CRC-16 (x^16 + x^12 + x^5 + 1) generator/appender for the reader
// transmit path, placed between the command framer and the line encoder.
// Payload bits pass through one registered output stage while the CRC is
// accumulated.  After the bit flagged in_last, the 16-bit CRC (complemented
// when INVERT = 1) is shifted out MSB first, and out_last marks its final bit.
//
// Ports:
//   clk      - system clock, rising edge
//   rst_n    - asynchronous active-low reset
//   clr      - synchronous frame abort, back to PASS with CRC = PRESET
//   in_dat   - payload bit          in_vld  - payload bit valid
//   in_last  - final payload bit    in_rdy  - payload bit accepted this cycle
//   out_dat  - output bit           out_vld - output bit valid
//   out_last - final appended CRC bit
//   out_rdy  - downstream takes out_dat this cycle
//   crc      - current CRC register (visibility only)
//   busy     - high while the CRC is being appended
module crc16_tx_append #(
  parameter logic [15:0] PRESET = 16'hFFFF,
  parameter bit          INVERT = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        in_dat,
  input  logic        in_vld,
  input  logic        in_last,
  output logic        in_rdy,
  output logic        out_dat,
  output logic        out_vld,
  output logic        out_last,
  input  logic        out_rdy,
  output logic [15:0] crc,
  output logic        busy
);

  typedef enum logic {
    PASS   = 1'b0,
    APPEND = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] crc_q, crc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        out_dat_q, out_dat_d;
  logic        out_vld_q, out_vld_d;
  logic        out_last_q, out_last_d;
  logic        free_s;

  // One serial CRC step: feedback only when the incoming bit differs from the MSB.
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    logic fb;
    fb = b ^ c[15];
    crc_step = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  // The output register can take a new bit when empty or being drained now.
  assign free_s   = ~out_vld_q | out_rdy;
  assign in_rdy   = (state_q == PASS) & free_s & ~clr;
  assign out_dat  = out_dat_q;
  assign out_vld  = out_vld_q;
  assign out_last = out_last_q;
  assign crc      = crc_q;
  assign busy     = (state_q == APPEND);

  // Next-state logic: clr overrides everything, otherwise pass or append.
  always_comb begin
    state_d    = state_q;
    crc_d      = crc_q;
    cnt_d      = cnt_q;
    out_dat_d  = out_dat_q;
    out_vld_d  = out_vld_q;
    out_last_d = out_last_q;
    if (clr) begin
      state_d    = PASS;
      crc_d      = PRESET;
      cnt_d      = 4'd0;
      out_vld_d  = 1'b0;
      out_last_d = 1'b0;
    end else begin
      case (state_q)
        PASS: begin
          if (in_vld && in_rdy) begin
            out_dat_d  = in_dat;
            out_vld_d  = 1'b1;
            out_last_d = 1'b0;
            crc_d      = crc_step(crc_q, in_dat);
            if (in_last) begin
              state_d = APPEND;
              cnt_d   = 4'd0;
            end else begin
              state_d = PASS;
            end
          end else if (out_vld_q && out_rdy) begin
            out_vld_d  = 1'b0;
            out_last_d = 1'b0;
          end else begin
            out_vld_d = out_vld_q;
          end
        end
        APPEND: begin
          if (free_s) begin
            // Plain shift: the CRC is emitted, not folded back in.
            out_dat_d  = crc_q[15] ^ INVERT;
            out_vld_d  = 1'b1;
            out_last_d = 1'b0;
            crc_d      = {crc_q[14:0], 1'b0};
            cnt_d      = cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
              out_last_d = 1'b1;
              crc_d      = PRESET;
              state_d    = PASS;
            end else begin
              state_d = APPEND;
            end
          end else begin
            state_d = APPEND;
          end
        end
        default: begin
          state_d    = PASS;
          crc_d      = PRESET;
          cnt_d      = 4'd0;
          out_vld_d  = 1'b0;
          out_last_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= PASS;
      crc_q      <= PRESET;
      cnt_q      <= 4'd0;
      out_dat_q  <= 1'b0;
      out_vld_q  <= 1'b0;
      out_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      crc_q      <= crc_d;
      cnt_q      <= cnt_d;
      out_dat_q  <= out_dat_d;
      out_vld_q  <= out_vld_d;
      out_last_q <= out_last_d;
    end
  end

endmodule

// File: tb/tb_crc16_tx_append.sv
// Directed bench for crc16_tx_append: echo/latency, appended CRC values,
// receive-side residue, backpressure, back-to-back frames, clr and rst_n.
module tb_crc16_tx_append;

  logic        clk = 1'b0;
  logic        rst_n, clr, in_dat, in_vld, in_last, out_rdy;
  logic        in_rdy, out_dat, out_vld, out_last, busy;
  logic [15:0] crc_o;
  // Second instance with INVERT = 0.
  logic        b_dat, b_vld, b_last, b_in_rdy, b_out_dat, b_out_vld, b_out_last, b_busy;
  logic [15:0] b_crc;

  crc16_tx_append dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_dat(in_dat), .in_vld(in_vld),
    .in_last(in_last), .in_rdy(in_rdy), .out_dat(out_dat), .out_vld(out_vld),
    .out_last(out_last), .out_rdy(out_rdy), .crc(crc_o), .busy(busy)
  );

  crc16_tx_append #(.PRESET(16'hFFFF), .INVERT(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr(1'b0), .in_dat(b_dat), .in_vld(b_vld),
    .in_last(b_last), .in_rdy(b_in_rdy), .out_dat(b_out_dat), .out_vld(b_out_vld),
    .out_last(b_out_last), .out_rdy(1'b1), .crc(b_crc), .busy(b_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic pay;
    logic dat;
    logic last;
  } ent_t;

  ent_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          busy_cnt = 0;
  logic        rnd_rdy = 1'b0;
  logic        last_acc = 1'b0;
  logic [15:0] rx_crc = 16'hFFFF;
  logic [15:0] crc_cap = 16'h0000;
  logic [15:0] last_crc = 16'h0000;
  logic [199:0] frame;
  logic [199:0] digits;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic flush();
    exp_q.delete();
    rx_crc  = 16'hFFFF;
    crc_cap = 16'h0000;
  endtask

  // One clock: score the transfer and acceptance, then check after the edge.
  task automatic step();
    logic acc, acc_dat, xfer, stall, hold_dat, hold_last, fb;
    ent_t e;
    #1;
    acc       = in_vld & in_rdy;
    acc_dat   = in_dat;
    xfer      = out_vld & out_rdy;
    stall     = out_vld & ~out_rdy & ~clr;
    hold_dat  = out_dat;
    hold_last = out_last;
    if (xfer) begin
      if (exp_q.size() == 0) begin
        chk("out_unexpected", {31'd0, out_vld}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        if (e.pay) chk("payload_echo", {31'd0, out_dat}, {31'd0, e.dat});
        else crc_cap = {crc_cap[14:0], out_dat};
        chk("out_last", {31'd0, out_last}, {31'd0, e.last});
      end
      fb = out_dat ^ rx_crc[15];
      rx_crc = {rx_crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      if (out_last) begin
        chk("rx_residue", {16'd0, rx_crc}, 32'h1D0F);
        rx_crc   = 16'hFFFF;
        last_crc = crc_cap;
      end
    end
    if (acc) begin
      exp_q.push_back('{pay: 1'b1, dat: acc_dat, last: 1'b0});
      if (in_last) begin
        for (int k = 0; k < 16; k++) exp_q.push_back('{pay: 1'b0, dat: 1'b0, last: (k == 15)});
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (busy) busy_cnt++;
    if (acc) chk("latency1", {30'd0, out_vld, out_dat}, {30'd0, 1'b1, acc_dat});
    if (stall) chk("stall_hold", {30'd0, out_dat, out_last}, {30'd0, hold_dat, hold_last});
    if (rnd_rdy) out_rdy = 1'($urandom_range(0, 1));
    last_acc = acc;
  endtask

  task automatic send_frame(input logic [199:0] bits, input int n);
    int g;
    for (int i = 0; i < n; i++) begin
      in_vld  = 1'b1;
      in_dat  = bits[n-1-i];
      in_last = (i == n - 1);
      g = 0;
      step();
      while (!last_acc && g < 500) begin
        step();
        g++;
      end
      if (!last_acc) chk("accept_timeout", {31'd0, last_acc}, 32'd1);
    end
  endtask

  task automatic drain();
    int g;
    in_vld  = 1'b0;
    in_last = 1'b0;
    in_dat  = 1'b0;
    g = 0;
    while (exp_q.size() > 0 && g < 2000) begin
      step();
      g++;
    end
    chk("drain_left", exp_q.size(), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; in_dat = 1'b0; in_vld = 1'b0; in_last = 1'b0; out_rdy = 1'b1;
    b_dat = 1'b0; b_vld = 1'b0; b_last = 1'b0;
    digits = '0;
    digits[71:0] = 72'h313233343536373839;  // "123456789"
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", {29'd0, out_vld, out_dat, out_last}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_crc", {16'd0, crc_o}, 32'hFFFF);
    chk("rst_in_rdy", {31'd0, in_rdy}, 32'd1);
    rst_n = 1'b1;

    // "123456789", out_rdy held high.
    cyc = 0; busy_cnt = 0;
    send_frame(digits, 72);
    drain();
    chk("check_crc", {16'd0, last_crc}, 32'hD64E);
    chk("busy_cycles", busy_cnt, 32'd16);
    chk("no_bubble_cycles", cyc, 32'd89);
    chk("crc_preset_after", {16'd0, crc_o}, 32'hFFFF);

    // Single payload bit 0.
    frame = '0;
    send_frame(frame, 1);
    drain();
    chk("single_crc", {16'd0, last_crc}, 32'h1020);
    chk("single_preset", {16'd0, crc_o}, 32'hFFFF);

    // Random frames with random backpressure.
    rnd_rdy = 1'b1;
    for (int f = 0; f < 6; f++) begin
      for (int w = 0; w < 7; w++) frame[w*32 +: 32] = $urandom;
      send_frame(frame, $urandom_range(1, 200));
      drain();
    end
    send_frame(digits, 72);
    drain();
    chk("stalled_check_crc", {16'd0, last_crc}, 32'hD64E);
    rnd_rdy = 1'b0;
    out_rdy = 1'b1;

    // Back-to-back: second frame bit waits only through the CRC append.
    cyc = 0;
    frame = '0;
    send_frame(digits, 72);
    send_frame(frame, 1);
    drain();
    chk("b2b_cycles", cyc, 32'd106);
    chk("b2b_second_crc", {16'd0, last_crc}, 32'h1020);

    // clr at cnt = 7 inside APPEND.
    send_frame(digits, 72);
    in_vld = 1'b0; in_last = 1'b0;
    repeat (7) step();
    chk("busy_before_clr", {31'd0, busy}, 32'd1);
    clr = 1'b1;
    #1;
    chk("clr_in_rdy", {31'd0, in_rdy}, 32'd0);
    step();
    clr = 1'b0;
    chk("clr_out", {30'd0, out_vld, out_last}, 32'd0);
    chk("clr_state", {15'd0, busy, crc_o}, 32'hFFFF);
    flush();
    send_frame(digits, 72);
    drain();
    chk("after_clr_crc", {16'd0, last_crc}, 32'hD64E);

    // rst_n mid-payload.
    for (int i = 0; i < 20; i++) begin
      in_vld = 1'b1; in_dat = digits[71-i]; in_last = 1'b0;
      step();
    end
    in_vld = 1'b0;
    chk("pre_rst_vld", {31'd0, out_vld}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_out", {29'd0, out_vld, out_dat, out_last}, 32'd0);
    chk("rst_mid_crc", {15'd0, busy, crc_o}, 32'hFFFF);
    @(posedge clk);
    #1 rst_n = 1'b1;
    flush();
    send_frame(digits, 72);
    drain();
    chk("after_rst_crc", {16'd0, last_crc}, 32'hD64E);

    // INVERT = 0 instance: single bit 0 gives 0 then raw CRC 0xEFDF.
    b_vld = 1'b1; b_dat = 1'b0; b_last = 1'b1;
    #1;
    chk("b_in_rdy", {31'd0, b_in_rdy}, 32'd1);
    step();
    b_vld = 1'b0; b_last = 1'b0;
    chk("b_first", {30'd0, b_out_vld, b_out_dat}, 32'd2);
    crc_cap = 16'h0000;
    for (int k = 0; k < 16; k++) begin
      step();
      crc_cap = {crc_cap[14:0], b_out_dat};
      if (k == 15) chk("b_out_last", {31'd0, b_out_last}, 32'd1);
    end
    chk("b_raw_crc", {16'd0, crc_cap}, 32'hEFDF);
    chk("b_preset", {16'd0, b_crc}, 32'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
